ex_mem_stage: RTL and testbench

- Execute-to-memory pipeline stage that sits directly downstream of the ALU.
- Decides each cycle whether the EX-stage instruction has finished, including sequential-shifter ops that need several cycles and signal progress on the ALU busy line.
- Registers the ALU result and the memory/writeback control fields into the EX/MEM pipeline register.
- Generates the EX stall back to upstream stages and the EX/MEM forwarding port.

---
 rtl/ex_mem_stage.sv | 186 ++++++++++++++++++
 tb/tb_ex_mem_stage.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_mem_stage.sv
// ex_mem_stage: execute-to-memory pipeline stage.
// Decides when the EX instruction has finished (single-cycle ops or the
// sequential shifter), loads the EX/MEM pipeline register, raises the EX
// stall towards IF/ID/EX and drives the EX/MEM forwarding port.
// Optional feature macro: EX_FORWARD_EN (forwarding port live when defined,
// tied to zero otherwise).
module ex_mem_stage #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
) (
  input  logic              i_clk_n,
  input  logic              i_rst_n,
  input  logic              i_valid,
  input  logic              i_multicycle,
  input  logic              i_flush,
  input  logic [DATA_W-1:0] i_alu_out,
  input  logic              i_alu_busy,
  input  logic [REG_W-1:0]  i_rd,
  input  logic              i_rd_we,
  input  logic              i_mem_re,
  input  logic              i_mem_we,
  input  logic [2:0]        i_funct3,
  input  logic [DATA_W-1:0] i_store_data,
  input  logic              i_mem_stall,
  output logic              o_ex_stall,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_result,
  output logic [REG_W-1:0]  o_rd,
  output logic              o_rd_we,
  output logic              o_mem_re,
  output logic              o_mem_we,
  output logic [2:0]        o_funct3,
  output logic [DATA_W-1:0] o_store_data,
  output logic              o_fwd_valid,
  output logic [REG_W-1:0]  o_fwd_rd,
  output logic [DATA_W-1:0] o_fwd_data
);

  // Everything the EX/MEM register carries for one instruction.
  typedef struct packed {
    logic [DATA_W-1:0] result;
    logic [REG_W-1:0]  rd;
    logic              rd_we;
    logic              mem_re;
    logic              mem_we;
    logic [2:0]        funct3;
    logic [DATA_W-1:0] store_data;
  } stage_t;

  // IDLE: normal issue; ISSUE: shifter just launched, busy not yet valid;
  // WAIT: shifter running; HOLD: finished but MEM stalled, result parked.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_HOLD  = 2'd3
  } state_t;

  state_t state_q, state_d;
  stage_t hold_q, hold_d;
  stage_t out_q, out_d;
  logic   valid_q, valid_d;

  logic   live;
  logic   capture;
  stage_t in_fields;
  stage_t cap_src;

  // A dropped i_valid is handled exactly like a flush.
  assign live = i_valid && !i_flush;

  assign in_fields = '{
    result:     i_alu_out,
    rd:         i_rd,
    rd_we:      i_rd_we,
    mem_re:     i_mem_re,
    mem_we:     i_mem_we,
    funct3:     i_funct3,
    store_data: i_store_data
  };

  // Next-state, completion detection and hold-register capture.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    capture = 1'b0;
    cap_src = in_fields;
    unique case (state_q)
      ST_IDLE: begin
        if (live && !i_alu_busy) begin
          if (i_multicycle) begin
            // The shifter latches its operands at this edge.
            state_d = ST_ISSUE;
          end else if (!i_mem_stall) begin
            capture = 1'b1;
          end
          // A finished single-cycle op under a MEM stall just waits here:
          // its combinational result stays stable while EX is held.
        end
        // live && busy: a leftover shift is still draining, keep stalling.
      end
      ST_ISSUE: begin
        // Busy is only meaningful one cycle after launch.
        state_d = live ? ST_WAIT : ST_IDLE;
      end
      ST_WAIT: begin
        if (!live) begin
          state_d = ST_IDLE;
        end else if (!i_alu_busy) begin
          if (i_mem_stall) begin
            // Park the result: the ALU is free to relaunch from now on.
            hold_d  = in_fields;
            state_d = ST_HOLD;
          end else begin
            capture = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
      ST_HOLD: begin
        // Already complete, so a flush no longer affects it.
        cap_src = hold_q;
        if (!i_mem_stall) begin
          capture = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // EX/MEM register: load on capture, drain when MEM moves, freeze on stall.
  always_comb begin
    out_d   = out_q;
    valid_d = valid_q;
    if (capture) begin
      out_d   = cap_src;
      valid_d = 1'b1;
    end else if (!i_mem_stall) begin
      valid_d      = 1'b0;
      out_d.rd_we  = 1'b0;
      out_d.mem_re = 1'b0;
      out_d.mem_we = 1'b0;
    end
  end

  // State, hold register and EX/MEM register flops.
  always_ff @(posedge i_clk_n or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      hold_q  <= '0;
      out_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      out_q   <= out_d;
      valid_q <= valid_d;
    end
  end

  // Stall is released only in the cycle the instruction is captured;
  // forced low while reset is held so every output reads 0.
  assign o_ex_stall = i_rst_n && live && !capture;

  assign o_valid      = valid_q;
  assign o_result     = out_q.result;
  assign o_rd         = out_q.rd;
  assign o_rd_we      = valid_q && out_q.rd_we;
  assign o_mem_re     = valid_q && out_q.mem_re;
  assign o_mem_we     = valid_q && out_q.mem_we;
  assign o_funct3     = out_q.funct3;
  assign o_store_data = out_q.store_data;

`ifdef EX_FORWARD_EN
  // Loads are excluded: their data only exists after the MEM stage.
  assign o_fwd_valid = valid_q && out_q.rd_we && !out_q.mem_re && (out_q.rd != '0);
  assign o_fwd_rd    = out_q.rd;
  assign o_fwd_data  = out_q.result;
`else
  assign o_fwd_valid = 1'b0;
  assign o_fwd_rd    = '0;
  assign o_fwd_data  = '0;
`endif

endmodule

// File: tb/tb_ex_mem_stage.sv
// Bench for ex_mem_stage: table of single-cycle ops plus hand-written
// multi-cycle sequences; captures are checked through a scoreboard queue.
module tb_ex_mem_stage;

`ifdef EX_FORWARD_EN
  localparam bit FWD_EN = 1'b1;
`else
  localparam bit FWD_EN = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        valid, multicycle, flush, alu_busy;
  logic [31:0] alu_out;
  logic [4:0]  rd;
  logic        rd_we, mem_re, mem_we;
  logic [2:0]  funct3;
  logic [31:0] store_data;
  logic        mem_stall;

  logic        o_ex_stall, o_valid;
  logic [31:0] o_result;
  logic [4:0]  o_rd;
  logic        o_rd_we, o_mem_re, o_mem_we;
  logic [2:0]  o_funct3;
  logic [31:0] o_store_data;
  logic        o_fwd_valid;
  logic [4:0]  o_fwd_rd;
  logic [31:0] o_fwd_data;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] result;
    logic [4:0]  rd;
    logic        rd_we;
    logic        mem_re;
    logic        mem_we;
    logic [2:0]  f3;
    logic [31:0] sd;
  } exp_t;

  typedef struct {
    logic [31:0] alu;
    logic [4:0]  rd;
    logic        rd_we;
    logic        mem_re;
    logic        mem_we;
    logic [2:0]  f3;
    logic [31:0] sd;
    logic        fwd;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[7];

  ex_mem_stage #(.DATA_W(32), .REG_W(5)) dut (
    .i_clk_n      (clk),
    .i_rst_n      (rst_n),
    .i_valid      (valid),
    .i_multicycle (multicycle),
    .i_flush      (flush),
    .i_alu_out    (alu_out),
    .i_alu_busy   (alu_busy),
    .i_rd         (rd),
    .i_rd_we      (rd_we),
    .i_mem_re     (mem_re),
    .i_mem_we     (mem_we),
    .i_funct3     (funct3),
    .i_store_data (store_data),
    .i_mem_stall  (mem_stall),
    .o_ex_stall   (o_ex_stall),
    .o_valid      (o_valid),
    .o_result     (o_result),
    .o_rd         (o_rd),
    .o_rd_we      (o_rd_we),
    .o_mem_re     (o_mem_re),
    .o_mem_we     (o_mem_we),
    .o_funct3     (o_funct3),
    .o_store_data (o_store_data),
    .o_fwd_valid  (o_fwd_valid),
    .o_fwd_rd     (o_fwd_rd),
    .o_fwd_data   (o_fwd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%08h expected=%08h @%0t", name, act, exp, $time);
    end else begin
      $display("ok   %s value=%08h @%0t", name, act, $time);
    end
  endtask

  task automatic push_cur();
    exp_t e;
    e.result = alu_out; e.rd = rd; e.rd_we = rd_we; e.mem_re = mem_re;
    e.mem_we = mem_we;  e.f3 = funct3; e.sd = store_data;
    sb.push_back(e);
  endtask

  task automatic drive_idle();
    valid = 1'b0; multicycle = 1'b0; flush = 1'b0; alu_busy = 1'b0;
    alu_out = '0; rd = '0; rd_we = 1'b0; mem_re = 1'b0; mem_we = 1'b0;
    funct3 = '0; store_data = '0; mem_stall = 1'b0;
  endtask

  task automatic chk_fwd(input vec_t v);
    chk("fwd_valid", {31'd0, o_fwd_valid}, {31'd0, FWD_EN & v.fwd});
    chk("fwd_rd",    {27'd0, o_fwd_rd},    FWD_EN ? {27'd0, v.rd} : 32'd0);
    chk("fwd_data",  o_fwd_data,           FWD_EN ? v.alu : 32'd0);
  endtask

  // Scoreboard monitor: after an edge with no MEM stall, o_valid=1 means a
  // fresh capture happened at that edge.
  initial begin
    logic stall_s;
    exp_t e;
    forever begin
      @(posedge clk);
      stall_s = mem_stall;
      #1;
      if (rst_n && !stall_s && o_valid) begin
        if (sb.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_capture actual result=%08h required=no capture @%0t", o_result, $time);
        end else begin
          e = sb.pop_front();
          chk("cap_result", o_result, e.result);
          chk("cap_rd",     {27'd0, o_rd}, {27'd0, e.rd});
          chk("cap_ctrl",   {29'd0, o_rd_we, o_mem_re, o_mem_we}, {29'd0, e.rd_we, e.mem_re, e.mem_we});
          chk("cap_funct3", {29'd0, o_funct3}, {29'd0, e.f3});
          chk("cap_sdata",  o_store_data, e.sd);
        end
      end
    end
  end

  initial begin
    vecs[0] = '{32'h0000_0007, 5'd3,  1'b1, 1'b0, 1'b0, 3'd0, 32'h0,         1'b1};
    vecs[1] = '{32'h1000_0040, 5'd0,  1'b1, 1'b1, 1'b0, 3'd2, 32'h0,         1'b0};
    vecs[2] = '{32'h2000_0008, 5'd0,  1'b0, 1'b0, 1'b1, 3'd2, 32'hcafe_babe, 1'b0};
    vecs[3] = '{32'h0000_0044, 5'd5,  1'b1, 1'b1, 1'b0, 3'd4, 32'h0,         1'b0};
    vecs[4] = '{32'hffff_ffff, 5'd31, 1'b1, 1'b0, 1'b0, 3'd0, 32'h0,         1'b1};
    vecs[5] = '{32'h0000_005a, 5'd0,  1'b1, 1'b0, 1'b0, 3'd0, 32'h0,         1'b0};
    vecs[6] = '{32'h0000_1234, 5'd12, 1'b0, 1'b0, 1'b0, 3'd1, 32'h0,         1'b0};

    // Reset state
    rst_n = 1'b0;
    drive_idle();
    repeat (2) @(negedge clk);
    chk("rst_valid",  {31'd0, o_valid},    32'd0);
    chk("rst_result", o_result,            32'd0);
    chk("rst_stall",  {31'd0, o_ex_stall}, 32'd0);
    chk("rst_fwd",    {31'd0, o_fwd_valid},32'd0);
    rst_n = 1'b1;

    // Table of single-cycle ops, back to back
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      if (i > 0) chk_fwd(vecs[i-1]);
      valid = 1'b1; multicycle = 1'b0; alu_busy = 1'b0;
      alu_out = vecs[i].alu; rd = vecs[i].rd; rd_we = vecs[i].rd_we;
      mem_re = vecs[i].mem_re; mem_we = vecs[i].mem_we;
      funct3 = vecs[i].f3; store_data = vecs[i].sd;
      #1 chk("single_stall", {31'd0, o_ex_stall}, 32'd0);
      push_cur();
    end
    @(negedge clk);
    chk_fwd(vecs[6]);
    drive_idle();
    @(negedge clk);
    chk("drain_valid", {31'd0, o_valid}, 32'd0);

    // Shift by 4: stall for 5 cycles, capture on edge 6
    valid = 1'b1; multicycle = 1'b1; alu_out = 32'hdead_0000; rd = 5'd10; rd_we = 1'b1;
    #1 chk("shift_stall_c0", {31'd0, o_ex_stall}, 32'd1);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      alu_busy = 1'b1; alu_out = k;
      #1 chk("shift_stall_busy", {31'd0, o_ex_stall}, 32'd1);
    end
    @(negedge clk);
    alu_busy = 1'b0; alu_out = 32'h0000_0010;
    #1 chk("shift_stall_done", {31'd0, o_ex_stall}, 32'd0);
    push_cur();
    @(negedge clk);
    drive_idle(); alu_out = 32'hffff_0000;
    chk("shift_valid",  {31'd0, o_valid}, 32'd1);
    chk("shift_result", o_result, 32'h0000_0010);

    // Shift completing under a 3-cycle MEM stall -> HOLD; flush ignored in HOLD
    @(negedge clk);
    valid = 1'b1; multicycle = 1'b1; rd = 5'd11; rd_we = 1'b1;
    @(negedge clk); alu_busy = 1'b1;
    @(negedge clk); alu_busy = 1'b1;
    @(negedge clk);
    alu_busy = 1'b0; alu_out = 32'h0000_0055; mem_stall = 1'b1;
    #1 chk("hold_stall_done", {31'd0, o_ex_stall}, 32'd1);
    @(negedge clk);
    alu_busy = 1'b1; alu_out = 32'h0000_0bad;
    #1 chk("hold_stall_1", {31'd0, o_ex_stall}, 32'd1);
    @(negedge clk);
    #1 chk("hold_stall_2", {31'd0, o_ex_stall}, 32'd1);
    @(negedge clk);
    mem_stall = 1'b0; flush = 1'b1;
    #1 chk("hold_flush_stall", {31'd0, o_ex_stall}, 32'd0);
    begin
      exp_t e;
      e.result = 32'h0000_0055; e.rd = 5'd11; e.rd_we = 1'b1; e.mem_re = 1'b0;
      e.mem_we = 1'b0; e.f3 = 3'd0; e.sd = 32'h0;
      sb.push_back(e);
    end
    @(negedge clk);
    drive_idle();
    chk("hold_valid",  {31'd0, o_valid}, 32'd1);
    chk("hold_result", o_result, 32'h0000_0055);

    // Flush in WAIT, then a single-cycle op behind a draining shift
    @(negedge clk);
    valid = 1'b1; multicycle = 1'b1; rd = 5'd12;
    @(negedge clk); alu_busy = 1'b1;
    @(negedge clk); flush = 1'b1;
    #1 chk("flush_stall", {31'd0, o_ex_stall}, 32'd0);
    @(negedge clk);
    flush = 1'b0; multicycle = 1'b0; alu_out = 32'h0000_0099; rd = 5'd7; rd_we = 1'b1;
    chk("flush_valid", {31'd0, o_valid}, 32'd0);
    #1 chk("drain_stall_0", {31'd0, o_ex_stall}, 32'd1);
    @(negedge clk);
    #1 chk("drain_stall_1", {31'd0, o_ex_stall}, 32'd1);
    @(negedge clk);
    alu_busy = 1'b0;
    #1 chk("drain_stall_done", {31'd0, o_ex_stall}, 32'd0);
    push_cur();
    @(negedge clk);
    drive_idle();
    chk("drain_result", o_result, 32'h0000_0099);

    // Async reset mid-WAIT while the EX/MEM register is held by a MEM stall
    @(negedge clk);
    valid = 1'b1; alu_out = 32'h0000_1234; rd = 5'd9; rd_we = 1'b1;
    push_cur();
    @(negedge clk);
    multicycle = 1'b1; alu_out = '0; mem_stall = 1'b1;
    @(negedge clk); alu_busy = 1'b1;
    @(negedge clk);
    chk("pre_rst_valid",  {31'd0, o_valid}, 32'd1);
    chk("pre_rst_result", o_result, 32'h0000_1234);
    #2 rst_n = 1'b0;
    #1;
    chk("async_valid",  {31'd0, o_valid}, 32'd0);
    chk("async_result", o_result, 32'd0);
    chk("async_rd",     {27'd0, o_rd}, 32'd0);
    chk("async_ctrl",   {29'd0, o_rd_we, o_mem_re, o_mem_we}, 32'd0);
    chk("async_stall",  {31'd0, o_ex_stall}, 32'd0);
    @(negedge clk);
    drive_idle();
    rst_n = 1'b1;
    @(negedge clk);
    valid = 1'b1; multicycle = 1'b1; alu_out = 32'h0000_0077; rd = 5'd13; rd_we = 1'b1;
    #1 chk("post_rst_idle_stall", {31'd0, o_ex_stall}, 32'd1);
    @(negedge clk);
    #1 chk("post_rst_issue_stall", {31'd0, o_ex_stall}, 32'd1);
    @(negedge clk);
    #1 chk("post_rst_wait_done", {31'd0, o_ex_stall}, 32'd0);
    push_cur();
    @(negedge clk);
    drive_idle();
    chk("post_rst_result", o_result, 32'h0000_0077);

    @(negedge clk);
    chk("sb_empty", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
